// File: rtl/alu_ctrl_seq_if.sv
// Handshake bundle between issue, the ALU control sequencer and writeback.
// master drives ops and consumes results; slave is the sequencer.
interface alu_ctrl_seq_if #(
    parameter int OPC_W = 4,
    parameter int CNT_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [OPC_W-1:0] opcode;
    logic [CNT_W-1:0] alu_cnt;
    logic             mc_active;
    logic             out_valid;
    logic             out_ready;
    logic             illegal;

    modport master (
        output flush, in_valid, alu_op, opcode, out_ready,
        input  in_ready, alu_cnt, mc_active, out_valid, illegal
    );

    modport slave (
        input  flush, in_valid, alu_op, opcode, out_ready,
        output in_ready, alu_cnt, mc_active, out_valid, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with multi-cycle MUL/DIV sequencing,
// valid/ready on both sides, illegal-op flag and synchronous flush.
module alu_ctrl_seq #(
    parameter int OPC_W      = 4,
    parameter int CNT_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_ctrl_seq_if.slave  bus
);
    localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CYC_W = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CYC_W-1:0] MUL_N2 = CYC_W'(MUL_CYCLES - 2);
    localparam logic [CYC_W-1:0] DIV_N2 = CYC_W'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULTI,
        S_OUT
    } state_t;

    state_t           r_state;
    logic [CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_alu_cnt;
    logic             r_out_valid;
    logic             r_mc_active;
    logic             r_illegal;

    logic [CNT_W-1:0] w_code;
    logic             w_ill;
    logic             w_mul;
    logic             w_div;
    logic             w_r00;
    logic             w_alu;
    logic             w_in_ready;
    logic             w_accept;

    assign w_r00 = (bus.alu_op == 2'b00);
    assign w_alu = w_r00 && (bus.opcode >= OPC_W'(2))
                         && (bus.opcode <= OPC_W'(9));

    always_comb begin
        w_code = '0;
        w_ill  = 1'b0;
        w_mul  = 1'b0;
        w_div  = 1'b0;
        unique case (1'b1)
            (bus.alu_op == 2'b10): w_code = '0;
            (bus.alu_op == 2'b01): w_code = CNT_W'(1);
            w_alu: w_code = CNT_W'(bus.opcode - OPC_W'(2));
            (w_r00 && bus.opcode == OPC_W'(10)): begin
                w_code = CNT_W'(8);
                w_mul  = 1'b1;
            end
            (w_r00 && bus.opcode == OPC_W'(11)): begin
                w_code = CNT_W'(9);
                w_div  = 1'b1;
            end
            (w_r00 && bus.opcode == OPC_W'(12)): begin
                w_code = CNT_W'(10);
                w_div  = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // in_ready never looks at in_valid, so there is no in->out comb path
    assign w_in_ready = !bus.flush &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_OUT && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_alu_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_mc_active <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_alu_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_mc_active <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_MULTI: begin
                    if (r_cyc == '0) begin
                        r_state     <= S_OUT;
                        r_mc_active <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc - CYC_W'(1);
                    end
                end
                S_IDLE, S_OUT: begin
                    if (w_accept) begin
                        r_alu_cnt <= w_code;
                        r_illegal <= w_ill;
                        if (w_mul || w_div) begin
                            r_state     <= S_MULTI;
                            r_mc_active <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_cyc       <= w_mul ? MUL_N2 : DIV_N2;
                        end else begin
                            r_state     <= S_OUT;
                            r_mc_active <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_state == S_OUT && bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_cnt   = r_alu_cnt;
    assign bus.mc_active = r_mc_active;
    assign bus.out_valid = r_out_valid;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, latency,
// back-to-back, backpressure, flush and async reset sequences.
module tb_alu_ctrl_seq;
    logic clk;
    logic rst_n;

    alu_ctrl_seq_if #(.OPC_W(4), .CNT_W(4)) bus();

    alu_ctrl_seq #(
        .OPC_W(4), .CNT_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] opc;
        int         cnt;
        bit         ill;
        int         lat;
    } vec_t;

    typedef struct {
        int cnt;
        bit ill;
    } exp_t;

    vec_t tbl[14];
    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   e_cnt = 0;
    bit   e_ill = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: scoreboard sampling at negedge, return at posedge+1.
    task automatic cyc();
        @(negedge clk);
        if (bus.flush) begin
            q.delete();
        end else if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: got output cnt %0d expected none",
                             bus.alu_cnt);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_cnt", 32'(bus.alu_cnt), e.cnt);
                    chk("sb_ill", 32'(bus.illegal), 32'(e.ill));
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{e_cnt, e_ill});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] opc,
                         input int cnt, input bit ill);
        bus.alu_op   = op;
        bus.opcode   = opc;
        bus.in_valid = 1'b1;
        e_cnt        = cnt;
        e_ill        = ill;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit hold_ok;

        tbl[0]  = '{2'b00, 4'd5,  3,  1'b0, 1};
        tbl[1]  = '{2'b10, 4'd7,  0,  1'b0, 1};
        tbl[2]  = '{2'b01, 4'd3,  1,  1'b0, 1};
        tbl[3]  = '{2'b00, 4'd2,  0,  1'b0, 1};
        tbl[4]  = '{2'b00, 4'd9,  7,  1'b0, 1};
        tbl[5]  = '{2'b00, 4'd6,  4,  1'b0, 1};
        tbl[6]  = '{2'b00, 4'd10, 8,  1'b0, 4};
        tbl[7]  = '{2'b00, 4'd11, 9,  1'b0, 8};
        tbl[8]  = '{2'b00, 4'd12, 10, 1'b0, 8};
        tbl[9]  = '{2'b11, 4'd5,  0,  1'b1, 1};
        tbl[10] = '{2'b00, 4'd15, 0,  1'b1, 1};
        tbl[11] = '{2'b00, 4'd0,  0,  1'b1, 1};
        tbl[12] = '{2'b00, 4'd13, 0,  1'b1, 1};
        tbl[13] = '{2'b10, 4'd15, 0,  1'b0, 1};

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 2'b00;
        bus.opcode    = 4'd0;
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_ov",  32'(bus.out_valid), 0);
        chk("rst_mc",  32'(bus.mc_active), 0);
        chk("rst_ill", 32'(bus.illegal), 0);
        chk("rst_cnt", 32'(bus.alu_cnt), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 32'(bus.in_ready), 1);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].op, tbl[i].opc, tbl[i].cnt, tbl[i].ill);
            chk("tbl_rdy", 32'(bus.in_ready), 1);
            cyc();
            bus.in_valid = 1'b0;
            lat     = 1;
            hold_ok = 1'b1;
            while (!bus.out_valid && lat < 20) begin
                if (!bus.mc_active || bus.in_ready) hold_ok = 1'b0;
                cyc();
                lat++;
            end
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_mc_hold", 32'(hold_ok), 1);
            chk("tbl_cnt", 32'(bus.alu_cnt), tbl[i].cnt);
            chk("tbl_ill", 32'(bus.illegal), 32'(tbl[i].ill));
            cyc();
            chk("tbl_idle", 32'(bus.out_valid), 0);
        end

        // back-to-back single-cycle ops
        drive(2'b00, 4'd2, 0, 1'b0);
        chk("b2b_rdy0", 32'(bus.in_ready), 1);
        cyc();
        chk("b2b_cnt0", 32'(bus.alu_cnt), 0);
        drive(2'b00, 4'd3, 1, 1'b0);
        chk("b2b_rdy1", 32'(bus.in_ready), 1);
        cyc();
        chk("b2b_cnt1", 32'(bus.alu_cnt), 1);
        drive(2'b00, 4'd9, 7, 1'b0);
        chk("b2b_rdy2", 32'(bus.in_ready), 1);
        cyc();
        chk("b2b_cnt2", 32'(bus.alu_cnt), 7);
        chk("b2b_ov",   32'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        cyc();

        // backpressure, then release together with a new op
        bus.out_ready = 1'b0;
        drive(2'b00, 4'd4, 2, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        repeat (5) begin
            chk("bp_ov",  32'(bus.out_valid), 1);
            chk("bp_cnt", 32'(bus.alu_cnt), 2);
            chk("bp_ill", 32'(bus.illegal), 0);
            chk("bp_rdy", 32'(bus.in_ready), 0);
            cyc();
        end
        bus.out_ready = 1'b1;
        drive(2'b00, 4'd8, 6, 1'b0);
        chk("bp_rel_rdy", 32'(bus.in_ready), 1);
        cyc();
        chk("bp_new_cnt", 32'(bus.alu_cnt), 6);
        chk("bp_new_ov",  32'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        cyc();

        // flush in the 2nd MULTI cycle of a DIV, with an op offered
        drive(2'b00, 4'd11, 9, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("fl_mc_pre", 32'(bus.mc_active), 1);
        bus.flush = 1'b1;
        drive(2'b00, 4'd5, 3, 1'b0);
        chk("fl_rdy", 32'(bus.in_ready), 0);
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_mc",  32'(bus.mc_active), 0);
        chk("fl_ov",  32'(bus.out_valid), 0);
        chk("fl_cnt", 32'(bus.alu_cnt), 0);
        repeat (8) cyc();
        chk("fl_nopend", 32'(bus.out_valid), 0);

        // flush while holding an illegal result under backpressure
        bus.out_ready = 1'b0;
        drive(2'b11, 4'd5, 0, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("flo_ov_pre",  32'(bus.out_valid), 1);
        chk("flo_ill_pre", 32'(bus.illegal), 1);
        bus.flush = 1'b1;
        drive(2'b00, 4'd5, 3, 1'b0);
        chk("flo_rdy", 32'(bus.in_ready), 0);
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flo_ov",  32'(bus.out_valid), 0);
        chk("flo_ill", 32'(bus.illegal), 0);
        chk("flo_mc",  32'(bus.mc_active), 0);
        bus.out_ready = 1'b1;
        cyc();

        // asynchronous reset in the middle of a MUL
        drive(2'b00, 4'd10, 8, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        chk("ar_mc_pre", 32'(bus.mc_active), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mc",  32'(bus.mc_active), 0);
        chk("ar_ov",  32'(bus.out_valid), 0);
        chk("ar_cnt", 32'(bus.alu_cnt), 0);
        q.delete();
        cyc();
        rst_n = 1'b1;
        repeat (6) cyc();
        chk("ar_nopend", 32'(bus.out_valid), 0);

        chk("sb_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
